imem_access_arbiter: RTL and testbench
======================================

// Module: imem_access_arbiter
// PURPOSE
//  Shares the single-port instruction memory unit between two requesters:
//  the fetch stage (reads) and the program loader (writes).
//  Per cycle: arbitrates, drives the memory en/wen/addr/data_in lines, and
//  returns read data to fetch with a valid strobe.
//  A starvation guard bounds how long the loader can block fetch.
//  Sits between the fetch/loader logic and the instruction memory unit.
// PARAMETERS
//  ADDR_W        32  address width, fetch/loader/memory
//  DATA_W        32  instruction word width
//  STARVE_LIMIT  4   max consecutive denied fetch cycles before fetch wins (>=1)
//  CNT_W         16  width of statistics counters
// PORTS
//  clk           in   1       clock, all state on posedge
//  rst           in   1       synchronous active-high reset
//  f_req         in   1       fetch read request; held with f_addr until f_gnt
//  f_addr        in   ADDR_W  fetch word address
//  f_gnt         out  1       fetch request issued this cycle (combinational)
//  f_rvalid      out  1       f_rdata valid (cycle after f_gnt)
//  f_rdata       out  DATA_W  read word, equals mem_rdata when f_rvalid
//  l_req         in   1       loader write request; held with l_addr/l_wdata until l_gnt
//  l_addr        in   ADDR_W  loader word address
//  l_wdata       in   DATA_W  loader write data
//  l_gnt         out  1       write issued this cycle; memory updated at this edge
//  mem_en        out  1       to memory en
//  mem_wen       out  1       to memory wen
//  mem_addr      out  ADDR_W  to memory addr
//  mem_wdata     out  DATA_W  to memory data_in
//  mem_rdata     in   DATA_W  from memory data_out (1-cycle read latency)
//  stat_conflict out  CNT_W   cycles with f_req & l_req both high (saturating)
//  stat_starve   out  CNT_W   starvation overrides taken (saturating)
// BEHAVIOUR
//  - Reset: f_rvalid=0, f_rdata=0, starve_cnt=0, rd_pend=0, stats=0.
//    Combinational outputs are 0 while rst=1: f_gnt, l_gnt, mem_en, mem_wen.
//    mem_addr and mem_wdata are 0 while rst=1.
//  - Grant select (combinational, one winner per cycle):
//    * neither requesting: mem_en=0, no grant.
//    * fetch only: fetch wins.
//    * loader only: loader wins.
//    * both requesting: fetch wins iff starve_cnt==STARVE_LIMIT, else loader.
//  - Fetch win: f_gnt=1, mem_en=1, mem_wen=0, mem_addr=f_addr.
//  - Loader win: l_gnt=1, mem_en=1, mem_wen=1, mem_addr=l_addr,
//    mem_wdata=l_wdata.
//  - No grant: mem_addr and mem_wdata hold 0.
//  - starve_cnt (sat. at STARVE_LIMIT):
//    * +1 when f_req and fetch is denied;
//    * cleared on f_gnt;
//    * unchanged when f_req=0.
//  - FSM IDLE/RD_PEND (rd_pend reg):
//    * f_gnt -> RD_PEND next cycle;
//    * otherwise -> IDLE.
//    * In RD_PEND: f_rvalid=1 and f_rdata=mem_rdata, registered-through
//      (combinational from mem_rdata while rd_pend).
//    * f_rvalid=0 -> f_rdata=0.
//  - Back-to-back fetch grants allowed every cycle: full throughput, latency 1.
//  - Write then read of the same address in the next cycle returns the new
//    word (memory updated at the write edge).
//  - Read issued while a loader write to the same address wins the same
//    cycle: impossible, one winner per cycle.
//  - Reset mid-read: rd_pend cleared; f_rvalid for the in-flight read is
//    never asserted.
//  - Requests with rst=1 are ignored and not queued.
// CONFIGURATION
//  IMEM_ARB_STATS_EN defined:
//    * stat_conflict +1 each cycle f_req&l_req (rst=0);
//    * stat_starve +1 each cycle fetch wins because starve_cnt==STARVE_LIMIT;
//    * both saturate at all-ones.
//  IMEM_ARB_STATS_EN undefined: no counter registers; stat_* tied to 0.
// TESTING
//  Reset: assert rst 2 cycles with f_req=l_req=1 -> all outputs 0, mem_en=0,
//    no grants.
//  Fetch stream: f_req=1, f_addr=0,1,2 on consecutive gnt cycles
//    -> f_rvalid=1 on cycles 1..3 with mem[0],mem[1],mem[2].
//  Write/read: l_req, l_addr=0x10, l_wdata=0xDEADBEEF -> l_gnt;
//    next cycle fetch 0x10 -> f_rdata=0xDEADBEEF one cycle later.
//  Starvation (STARVE_LIMIT=4): l_req and f_req held high
//    -> l_gnt cycles 0..3, f_gnt cycle 4, l_gnt cycle 5;
//    stat_starve=1, stat_conflict=6 (STATS_EN).
//  Reset mid-read: f_gnt in cycle N, rst=1 in cycle N+1
//    -> f_rvalid stays 0; after release, mem_en=0 until a new request.
//  Stats off: compile without IMEM_ARB_STATS_EN, rerun starvation test
//    -> identical grants; stat_conflict=stat_starve=0.

Source files
------------

// File: rtl/imem_access_arbiter_if.sv
// Bundle between the instruction-memory arbiter and its neighbours.
// Macro: IMEM_ARB_STATS_EN (see imem_access_arbiter.sv) affects only stat_* values.
// Signals:
//   f_*    fetch read channel   (req/addr in, gnt/rvalid/rdata out)
//   l_*    loader write channel (req/addr/wdata in, gnt out)
//   mem_*  single-port instruction memory (en/wen/addr/wdata out, rdata in)
//   stat_* saturating statistics counters
// Modports: slave = arbiter side, master = requesters/memory side.
interface imem_access_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;

    logic              l_req;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_gnt;

    logic              mem_en;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [CNT_W-1:0]  stat_conflict;
    logic [CNT_W-1:0]  stat_starve;

    modport slave (
        input  f_req, f_addr, l_req, l_addr, l_wdata, mem_rdata,
        output f_gnt, f_rvalid, f_rdata, l_gnt,
        output mem_en, mem_wen, mem_addr, mem_wdata,
        output stat_conflict, stat_starve
    );

    modport master (
        output f_req, f_addr, l_req, l_addr, l_wdata, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, l_gnt,
        input  mem_en, mem_wen, mem_addr, mem_wdata,
        input  stat_conflict, stat_starve
    );
endinterface

// File: rtl/imem_access_arbiter.sv
// Shares a single-port instruction memory between the fetch stage (reads) and
// the program loader (writes). One winner per cycle; the loader normally wins a
// conflict, but once fetch has been denied STARVE_LIMIT consecutive cycles it
// wins the next conflict. Read data returns one cycle after f_gnt.
// Ports:
//   clk  clock, all state on posedge
//   rst  synchronous active-high reset
//   bus  imem_access_arbiter_if.slave (fetch, loader, memory and stats signals)
// Optional feature: define IMEM_ARB_STATS_EN to build the saturating
// conflict/starvation counters; otherwise stat_* are tied to zero.
module imem_access_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    imem_access_arbiter_if.slave  bus
);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);

    typedef enum logic {StIdle, StRdPend} state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          fetch_win, load_win, both_req, starve_win;

    // Grant select; requests seen during reset are dropped, not queued.
    always_comb begin
        both_req   = !rst && bus.f_req && bus.l_req;
        fetch_win  = !rst && bus.f_req && (!bus.l_req || starve_q == StarveMax);
        load_win   = !rst && bus.l_req && !fetch_win;
        starve_win = both_req && fetch_win;
    end

    always_comb begin
        bus.f_gnt     = fetch_win;
        bus.l_gnt     = load_win;
        bus.mem_en    = fetch_win || load_win;
        bus.mem_wen   = load_win;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (fetch_win) begin
            bus.mem_addr = bus.f_addr;
        end else if (load_win) begin
            bus.mem_addr  = bus.l_addr;
            bus.mem_wdata = bus.l_wdata;
        end
    end

    // Consecutive-denial counter, saturating at STARVE_LIMIT.
    always_comb begin
        starve_d = starve_q;
        if (fetch_win) begin
            starve_d = '0;
        end else if (bus.f_req && starve_q != StarveMax) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_comb begin
        state_d = fetch_win ? StRdPend : StIdle;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Gated by rst so a read in flight when reset arrives never reports valid.
    always_comb begin
        bus.f_rvalid = (state_q == StRdPend) && !rst;
        bus.f_rdata  = bus.f_rvalid ? bus.mem_rdata : '0;
    end

`ifdef IMEM_ARB_STATS_EN
    logic [CNT_W-1:0] conflict_q, conflict_d;
    logic [CNT_W-1:0] starve_stat_q, starve_stat_d;

    always_comb begin
        conflict_d    = conflict_q;
        starve_stat_d = starve_stat_q;
        if (both_req && conflict_q != '1) begin
            conflict_d = conflict_q + CNT_W'(1);
        end
        if (starve_win && starve_stat_q != '1) begin
            starve_stat_d = starve_stat_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q    <= '0;
            starve_stat_q <= '0;
        end else begin
            conflict_q    <= conflict_d;
            starve_stat_q <= starve_stat_d;
        end
    end

    assign bus.stat_conflict = conflict_q;
    assign bus.stat_starve   = starve_stat_q;
`else
    logic unused_stats;
    assign unused_stats      = both_req ^ starve_win;
    assign bus.stat_conflict = '0;
    assign bus.stat_starve   = '0;
`endif
endmodule

// File: tb/tb_imem_access_arbiter.sv
module tb_imem_access_arbiter;
    localparam int unsigned LIMIT = 4;
`ifdef IMEM_ARB_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_access_arbiter_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) bus_if ();

    imem_access_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (LIMIT),
        .CNT_W        (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    function automatic logic [31:0] init_word(input int a);
        return 32'h1000_0000 ^ (a * 32'h9E37_79B9);
    endfunction

    // Memory device: 1-cycle read latency, write at the edge.
    logic [31:0] dev_mem [256];
    bit          dev_written [256];
    always @(posedge clk) begin
        if (bus_if.mem_en) begin
            if (bus_if.mem_wen) begin
                dev_mem[bus_if.mem_addr[7:0]]     <= bus_if.mem_wdata;
                dev_written[bus_if.mem_addr[7:0]] <= 1'b1;
            end else begin
                bus_if.mem_rdata <= dev_written[bus_if.mem_addr[7:0]] ?
                                    dev_mem[bus_if.mem_addr[7:0]] :
                                    init_word(int'(bus_if.mem_addr[7:0]));
            end
        end
    end

    // Reference model state: contents, denial run, pending read, stats.
    logic [31:0] ref_mem [256];
    int          deny_run;
    bit          m_pend;
    logic [31:0] m_pend_data;
    int          m_conflict, m_starve;
    bit          last_ef, last_el;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs after negedge, check, then advance the model.
    task automatic step(input bit r, input bit fq, input logic [31:0] fa,
                        input bit lq, input logic [31:0] la, input logic [31:0] ld);
        bit ef, el;
        @(negedge clk);
        rst            = r;
        bus_if.f_req   = fq;
        bus_if.f_addr  = fa;
        bus_if.l_req   = lq;
        bus_if.l_addr  = la;
        bus_if.l_wdata = ld;
        #1;
        if (r) begin
            ef = 0; el = 0;
        end else if (fq && lq) begin
            ef = (deny_run >= LIMIT);
            el = !ef;
        end else begin
            ef = fq; el = lq;
        end
        chk("f_gnt", 32'(bus_if.f_gnt), 32'(ef));
        chk("l_gnt", 32'(bus_if.l_gnt), 32'(el));
        chk("mem_en", 32'(bus_if.mem_en), 32'(ef | el));
        chk("mem_wen", 32'(bus_if.mem_wen), 32'(el));
        chk("mem_addr", bus_if.mem_addr, ef ? fa : (el ? la : 32'h0));
        chk("mem_wdata", bus_if.mem_wdata, el ? ld : 32'h0);
        chk("f_rvalid", 32'(bus_if.f_rvalid), 32'(!r && m_pend));
        chk("f_rdata", bus_if.f_rdata, (!r && m_pend) ? m_pend_data : 32'h0);
        chk("stat_conflict", 32'(bus_if.stat_conflict), StatsEn ? m_conflict : 0);
        chk("stat_starve", 32'(bus_if.stat_starve), StatsEn ? m_starve : 0);
        if (r) begin
            deny_run = 0; m_pend = 0; m_conflict = 0; m_starve = 0;
        end else begin
            if (fq && lq) begin
                if (m_conflict < 65535) m_conflict++;
                if (ef && m_starve < 65535) m_starve++;
            end
            m_pend = ef;
            if (ef) begin
                m_pend_data = ref_mem[fa[7:0]];
                deny_run    = 0;
            end else if (fq && deny_run < LIMIT) begin
                deny_run++;
            end
            if (el) ref_mem[la[7:0]] = ld;
        end
        last_ef = ef;
        last_el = el;
    endtask

    initial begin
        bit          fq, lq;
        logic [31:0] fa, la, ld;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        deny_run = 0; m_pend = 0; m_pend_data = 0; m_conflict = 0; m_starve = 0;
        rst = 1'b1;
        bus_if.f_req = 0; bus_if.l_req = 0;
        bus_if.f_addr = 0; bus_if.l_addr = 0; bus_if.l_wdata = 0;

        // Reset with both requesting: everything quiet.
        step(1, 1, 32'h5, 1, 32'h6, 32'h1234);
        step(1, 1, 32'h5, 1, 32'h6, 32'h1234);
        chk("rst_mem_en", 32'(bus_if.mem_en), 32'h0);
        step(0, 0, 0, 0, 0, 0);

        // Fetch stream, back-to-back.
        step(0, 1, 32'h0, 0, 0, 0);
        step(0, 1, 32'h1, 0, 0, 0);
        chk("stream_rd0", bus_if.f_rdata, init_word(0));
        step(0, 1, 32'h2, 0, 0, 0);
        chk("stream_rd1", bus_if.f_rdata, init_word(1));
        step(0, 0, 0, 0, 0, 0);
        chk("stream_rd2", bus_if.f_rdata, init_word(2));

        // Write then read the same word next cycle.
        step(0, 0, 0, 1, 32'h10, 32'hDEAD_BEEF);
        step(0, 1, 32'h10, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("wr_rd", bus_if.f_rdata, 32'hDEAD_BEEF);

        // Starvation: both held, fetch wins only at cycle 4.
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 32'h20, 1, 32'h30 + i, 32'hC0DE_0000 + i);
            chk("starve_fgnt", 32'(bus_if.f_gnt), 32'(i == 4));
            chk("starve_lgnt", 32'(bus_if.l_gnt), 32'(i != 4));
        end
        step(0, 0, 0, 0, 0, 0);
        chk("starve_stat", 32'(bus_if.stat_starve), StatsEn ? 1 : 0);
        chk("conflict_stat", 32'(bus_if.stat_conflict), StatsEn ? 6 : 0);

        // Reset right after a fetch grant: no valid for that read.
        step(0, 1, 32'h3, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("midrd_rvalid", 32'(bus_if.f_rvalid), 32'h0);
        step(0, 0, 0, 0, 0, 0);
        chk("midrd_idle", 32'(bus_if.mem_en | bus_if.f_rvalid), 32'h0);

        // Random traffic; requests held until granted.
        fq = 0; lq = 0; fa = 0; la = 0; ld = 0;
        for (int c = 0; c < 600; c++) begin
            bit r;
            r = ($urandom_range(0, 63) == 0);
            if (!fq && $urandom_range(0, 3) != 0) begin
                fq = 1; fa = 32'($urandom_range(0, 15));
            end
            if (!lq && $urandom_range(0, 2) != 0) begin
                lq = 1; la = 32'($urandom_range(0, 15)); ld = $urandom;
            end
            step(r, fq, fa, lq, la, ld);
            if (last_ef) fq = 0;
            if (last_el) lq = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
